irq_collector: RTL and testbench
================================

// Module: irq_collector
// PURPOSE
//  Gathers single-cycle interrupt pulses from NUM_SRC minipit timer instances into
//  per-source pending bits, applies a mask, and presents the highest-priority
//  unmasked pending source to the CPU-side/JTAG-visible interface via a valid/ack
//  handshake. Sits directly downstream of the minipit `interrupting` outputs.
// PARAMETERS
//  NUM_SRC  4                 number of interrupt sources (1..16)
//  ID_W     $clog2(NUM_SRC)   width of presented source id (min 1)
// PORTS
//  clk         in   1        single clock; all logic on posedge
//  rst         in   1        reset, synchronous, active-high
//  irq_in      in   NUM_SRC  per-source event; each cycle high = one event
//  mask_we     in   1        write strobe for mask register
//  mask_wdata  in   NUM_SRC  new mask; 1 = source masked
//  ovf_clr     in   NUM_SRC  write-1-to-clear for overflow bits
//  irq_ack     in   1        consumer accepts presented id
//  irq_valid   out  1        an id is presented
//  irq_id      out  ID_W     presented source index
//  irq_line    out  1        level: OR of (pending & ~mask), registered
//  pending     out  NUM_SRC  pending register
//  mask        out  NUM_SRC  mask register
//  overflow    out  NUM_SRC  sticky: event arrived while already pending
// BEHAVIOUR
//  Reset: pending=0, mask=all-ones (everything masked), overflow=0, irq_valid=0,
//   irq_id=0, irq_line=0, FSM=IDLE. Reset mid-handshake drops the presentation.
//  Pending: irq_in[i] at edge N sets pending[i] after N. Masked sources still latch.
//  Overflow[i] set when irq_in[i]=1 and pending[i]=1 and pending[i] not cleared
//   by an ack in that same cycle. ovf_clr[i] with simultaneous new overflow: set wins.
//  Mask: mask_we loads mask_wdata at the edge; takes effect the next cycle.
//  FSM IDLE: if (pending & ~mask)!=0, capture lowest-index such source into irq_id,
//   assert irq_valid, go PRESENT. Else stay.
//  FSM PRESENT: irq_valid=1, irq_id held stable. On irq_ack=1: clear pending[irq_id],
//   drop irq_valid, go IDLE. Masking or clearing nothing retracts a presentation;
//   the id stays until acked.
//  irq_ack while irq_valid=0 is ignored.
//  Ack and new irq_in on same source, same cycle: set wins, pending stays 1, no overflow.
//  Latency: irq_in at edge N -> pending at N+1 -> irq_valid at N+2 (unmasked, IDLE).
//  Back-to-back: after ack at edge A, earliest next irq_valid at A+2 (one IDLE cycle).
//  irq_line = registered OR(pending & ~mask), one cycle after pending/mask update;
//   independent of FSM.
// STRUCTURE
//  Package irq_pkg: IRQ_NUM_SRC default constant; typedef enum {IRQ_IDLE,
//   IRQ_PRESENT} irq_state_t.
//  Sub-module irq_prio_enc: combinational lowest-index-first encoder,
//   NUM_SRC -> {any, ID_W index}.
//  Top holds pending/mask/overflow registers and the 2-state FSM.
// TESTING
//  Reset: after rst, mask=4'hF, pending=0, irq_valid=0; irq_in=4'h2 pulse ->
//   pending=4'h2, irq_valid stays 0, irq_line=0.
//  Unmask: mask=0, pulse irq_in[2] at N -> irq_valid=1, irq_id=2 at N+2; ack ->
//   pending=0, valid=0.
//  Priority: irq_in=4'hA same cycle -> id=1 first; ack -> one IDLE cycle -> id=3.
//  Overflow: two pulses on src 0 without ack -> overflow[0]=1; ovf_clr=4'h1 -> 0;
//   ack+pulse same cycle -> pending[0]=1, overflow stays 0.
//  Hold: present id=0, then mask=4'hF -> irq_valid,irq_id unchanged until ack.
//  Reset mid-PRESENT: rst asserted with valid=1 -> next cycle valid=0,
//   pending=0, mask=4'hF.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_pkg;

  localparam int IRQ_NUM_SRC = 4;

  typedef enum logic {
    IRQ_IDLE    = 1'b0,
    IRQ_PRESENT = 1'b1
  } irq_state_t;

endpackage : irq_pkg

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: req -> {any_vld, idx_dat}.
// Latency: purely combinational.
// Backpressure: none.
// Ports: req (NUM_SRC request vector), any_vld (some bit set),
//        idx_dat (index of lowest set bit, 0 when none).
module irq_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any_vld,
  output logic [ID_W-1:0]    idx_dat
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any_vld = 1'b0;
    idx_dat = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_vld = 1'b1;
        idx_dat = ID_W'(i);
      end
    end
  end

endmodule : irq_prio_enc

// File: rtl/irq_collector.sv
// Collects interrupt pulses into pending bits, masks them and presents the
// lowest-index unmasked source; irq_in -> pending 1 cycle -> irq_valid 1 more.
// Backpressure: a presented id is held until irq_ack; new events keep latching.
// Ports: clk/rst (sync, active-high); irq_in events; mask_we/mask_wdata mask
//        write; ovf_clr W1C overflow; irq_ack accept; irq_valid/irq_id
//        presentation; irq_line registered level; pending/mask/overflow state.
module irq_collector
  import irq_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic [NUM_SRC-1:0] ovf_clr,
  input  logic               irq_ack,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic               irq_line,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] overflow
);

  irq_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] overflow_q, overflow_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               line_q, line_d;

  logic [NUM_SRC-1:0] active;
  logic               any_vld;
  logic [ID_W-1:0]    enc_idx;
  logic               ack_fire;
  logic               capture;
  logic [NUM_SRC-1:0] ack_clr;

  assign active = pending_q & ~mask_q;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req     (active),
    .any_vld (any_vld),
    .idx_dat (enc_idx)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IRQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Masking never retracts a presentation; only ack does.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE:    if (any_vld) state_d = IRQ_PRESENT;
      IRQ_PRESENT: if (irq_ack) state_d = IRQ_IDLE;
      default:     state_d = IRQ_IDLE;
    endcase
  end

  // FSM: outputs / strobes
  always_comb begin
    irq_valid = (state_q == IRQ_PRESENT);
    ack_fire  = (state_q == IRQ_PRESENT) && irq_ack;
    capture   = (state_q == IRQ_IDLE) && any_vld;
  end

  // Datapath next-state
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = ack_fire && (id_q == ID_W'(i));
    end
    // A new event on the source being acked re-arms it: set wins over clear.
    pending_d  = (pending_q & ~ack_clr) | irq_in;
    // Overflow only when the event lands on a bit that stays pending anyway;
    // a fresh overflow beats a simultaneous write-1-to-clear.
    overflow_d = (overflow_q & ~ovf_clr) | (irq_in & pending_q & ~ack_clr);
    mask_d     = mask_we ? mask_wdata : mask_q;
    id_d       = capture ? enc_idx : id_q;
    line_d     = |active;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      mask_q     <= '1;
      overflow_q <= '0;
      id_q       <= '0;
      line_q     <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
      id_q       <= id_d;
      line_q     <= line_d;
    end
  end

  assign irq_id   = id_q;
  assign irq_line = line_q;
  assign pending  = pending_q;
  assign mask     = mask_q;
  assign overflow = overflow_q;

endmodule : irq_collector

// File: tb/tb_irq_collector.sv
module tb_irq_collector;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_in;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic [N-1:0] ovf_clr;
  logic         irq_ack;
  logic         irq_valid;
  logic [1:0]   irq_id;
  logic         irq_line;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic [N-1:0] overflow;

  int total = 0;
  int bad   = 0;

  // Reference model state: per-source flags plus the presented source number
  // (-1 when nothing is being presented).
  bit   m_pend [N];
  bit   m_mask [N];
  bit   m_ovf  [N];
  int   m_pres;
  int   m_id;
  bit   m_line;

  irq_collector dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ovf_clr    (ovf_clr),
    .irq_ack    (irq_ack),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_line   (irq_line),
    .pending    (pending),
    .mask       (mask),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] pack(input bit v [N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  // Apply the behavioural rules to one clock edge using the current inputs.
  task automatic model_edge();
    bit np [N];
    bit nm [N];
    bit no [N];
    int acked;
    int first;
    bit any_active;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_mask[i] = 1; m_ovf[i] = 0;
      end
      m_pres = -1; m_id = 0; m_line = 0;
      return;
    end
    acked = (m_pres >= 0 && irq_ack) ? m_pres : -1;
    first = -1;
    any_active = 0;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && !m_mask[i]) begin
        any_active = 1;
        if (first < 0) first = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      bool_update: begin
        bit ev;
        bit cleared;
        ev      = irq_in[i];
        cleared = (i == acked);
        np[i] = ev ? 1'b1 : (cleared ? 1'b0 : m_pend[i]);
        if (ev && m_pend[i] && !cleared) no[i] = 1;
        else if (ovf_clr[i])             no[i] = 0;
        else                             no[i] = m_ovf[i];
        nm[i] = mask_we ? mask_wdata[i] : m_mask[i];
      end
    end
    if (m_pres >= 0) begin
      if (acked >= 0) m_pres = -1;
    end else if (first >= 0) begin
      m_pres = first;
      m_id   = first;
    end
    m_line = any_active;
    m_pend = np;
    m_mask = nm;
    m_ovf  = no;
  endtask

  task automatic check_all();
    chk("valid",    irq_valid, (m_pres >= 0));
    chk("id",       irq_id,    m_id);
    chk("line",     irq_line,  m_line);
    chk("pending",  pending,   pack(m_pend));
    chk("mask",     mask,      pack(m_mask));
    chk("overflow", overflow,  pack(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic quiet();
    rst = 0; irq_in = '0; mask_we = 0; mask_wdata = '0; ovf_clr = '0; irq_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    quiet();
    m_pres = -1; m_id = 0; m_line = 0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_mask[i] = 1; m_ovf[i] = 0; end
    rst = 1;
    @(posedge clk); model_edge();
    tick();
    rst = 0;
    // Reset state
    chk("rst_mask",    mask,      4'hF);
    chk("rst_pending", pending,   4'h0);
    chk("rst_valid",   irq_valid, 1'b0);
    chk("rst_id",      irq_id,    2'd0);
    // Masked source still latches but is never presented
    irq_in = 4'h2; tick(); irq_in = '0;
    chk("masked_pend", pending, 4'h2);
    tick();
    chk("masked_valid", irq_valid, 1'b0);
    chk("masked_line",  irq_line,  1'b0);

    // Unmask, pulse source 2: valid two edges later
    do_reset();
    mask_we = 1; mask_wdata = 4'h0; tick(); mask_we = 0;
    irq_in = 4'h4; tick(); irq_in = '0;
    chk("lat_pend",   pending,   4'h4);
    chk("lat_valid1", irq_valid, 1'b0);
    tick();
    chk("lat_valid2", irq_valid, 1'b1);
    chk("lat_id",     irq_id,    2'd2);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("ack_pend",  pending,   4'h0);
    chk("ack_valid", irq_valid, 1'b0);

    // Priority: sources 1 and 3 together
    irq_in = 4'hA; tick(); irq_in = '0; tick();
    chk("prio_id1", irq_id, 2'd1);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("prio_gap", irq_valid, 1'b0);
    tick();
    chk("prio_valid3", irq_valid, 1'b1);
    chk("prio_id3",    irq_id,    2'd3);
    irq_ack = 1; tick(); irq_ack = 0; tick();

    // Overflow on source 0
    irq_in = 4'h1; tick(); tick(); irq_in = '0;
    chk("ovf_set", overflow[0], 1'b1);
    ovf_clr = 4'h1; tick(); ovf_clr = '0;
    chk("ovf_clr", overflow[0], 1'b0);
    chk("ovf_present", irq_valid, 1'b1);
    irq_ack = 1; irq_in = 4'h1; tick(); irq_ack = 0; irq_in = '0;
    chk("ackset_pend", pending[0],  1'b1);
    chk("ackset_ovf",  overflow[0], 1'b0);

    // Hold: masking everything does not retract the presentation
    tick(); tick();
    chk("hold_valid0", irq_valid, 1'b1);
    mask_we = 1; mask_wdata = 4'hF; tick(); mask_we = 0;
    tick(); tick();
    chk("hold_valid", irq_valid, 1'b1);
    chk("hold_id",    irq_id,    2'd0);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("hold_drop", irq_valid, 1'b0);

    // Reset while presenting
    mask_we = 1; mask_wdata = 4'h0; tick(); mask_we = 0;
    irq_in = 4'h8; tick(); irq_in = '0; tick();
    chk("midrst_pre", irq_valid, 1'b1);
    do_reset();
    chk("midrst_valid", irq_valid, 1'b0);
    chk("midrst_pend",  pending,   4'h0);
    chk("midrst_mask",  mask,      4'hF);

    // Randomised traffic against the model
    mask_we = 1; mask_wdata = 4'h0; tick();
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      irq_in     = N'($urandom & $urandom);
      mask_we    = ($urandom_range(0, 9) == 0);
      mask_wdata = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
      ovf_clr    = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      irq_ack    = $urandom_range(0, 1) == 1;
      tick();
    end
    quiet();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_irq_collector
